// File: rtl/avr_gpio_port_pkg.sv
// Shared register offsets and decode types for AVR-style GPIO ports.
// The offsets are relative to the port's PIN address.
package avr_gpio_port_pkg;

  localparam logic [5:0] OFS_PIN   = 6'd0;
  localparam logic [5:0] OFS_DDR   = 6'd1;
  localparam logic [5:0] OFS_PORT  = 6'd2;
  localparam logic [5:0] OFS_PCMSK = 6'd3;
  localparam logic [5:0] OFS_PCIF  = 6'd4;

  typedef enum logic [2:0] {
    RegNone,
    RegPin,
    RegDdr,
    RegPort,
    RegPcmsk,
    RegPcif
  } reg_sel_e;

  // Map an I/O address onto one of this port's registers.
  function automatic reg_sel_e decode_addr(input logic [5:0] addr, input logic [5:0] base);
    reg_sel_e sel;
    sel = RegNone;
    if (addr == base + OFS_PIN)        sel = RegPin;
    else if (addr == base + OFS_DDR)   sel = RegDdr;
    else if (addr == base + OFS_PORT)  sel = RegPort;
    else if (addr == base + OFS_PCMSK) sel = RegPcmsk;
    else if (addr == base + OFS_PCIF)  sel = RegPcif;
    return sel;
  endfunction

endpackage

// File: rtl/avr_gpio_port_sync_ff2.sv
// Two-flop vector synchroniser for asynchronous pad inputs.
// Both stages are cleared by the synchronous reset.
module sync_ff2 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

  assign o_q = r_s2;

endmodule

// File: rtl/avr_gpio_port.sv
// AVR-style GPIO port: PIN/DDR/PORT registers, pin-change mask and flag,
// OR-able read bus, and a synchronised view of the pads.
module avr_gpio_port
  import avr_gpio_port_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter logic [5:0]  BASE_ADDR = 6'h00
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       io_addr,
  input  logic             io_we,
  input  logic             io_re,
  input  logic [7:0]       io_din,
  output logic [7:0]       io_dout,
  output logic [WIDTH-1:0] pin_out,
  output logic [WIDTH-1:0] pin_en,
  input  logic [WIDTH-1:0] pin_in,
  output logic             irq
);

  logic [WIDTH-1:0] r_ddr;
  logic [WIDTH-1:0] r_port;
  logic [WIDTH-1:0] r_pcmsk;
  logic [WIDTH-1:0] r_prev;
  logic             r_flag;

  logic [WIDTH-1:0] w_sync;
  logic [WIDTH-1:0] w_chg;
  logic [WIDTH-1:0] w_wdata;
  reg_sel_e         w_sel;
  logic             w_clr;

  sync_ff2 #(
    .WIDTH(WIDTH)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .i_d(pin_in),
    .o_q(w_sync)
  );

  assign w_sel   = decode_addr(io_addr, BASE_ADDR);
  assign w_wdata = io_din[WIDTH-1:0];
  assign w_chg   = (w_sync ^ r_prev) & r_pcmsk;
  assign w_clr   = io_we && (w_sel == RegPcif) && io_din[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ddr   <= '0;
      r_port  <= '0;
      r_pcmsk <= '0;
      r_prev  <= '0;
      r_flag  <= 1'b0;
    end else begin
      r_prev <= w_sync;
      // A detected change takes priority so a clear never swallows a new edge.
      if (|w_chg)     r_flag <= 1'b1;
      else if (w_clr) r_flag <= 1'b0;
      if (io_we) begin
        case (w_sel)
          RegPin:   r_port  <= r_port ^ w_wdata;
          RegDdr:   r_ddr   <= w_wdata;
          RegPort:  r_port  <= w_wdata;
          RegPcmsk: r_pcmsk <= w_wdata;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    io_dout = 8'h00;
    if (io_re && !rst) begin
      unique case (w_sel)
        RegPin:   io_dout[WIDTH-1:0] = w_sync;
        RegDdr:   io_dout[WIDTH-1:0] = r_ddr;
        RegPort:  io_dout[WIDTH-1:0] = r_port;
        RegPcmsk: io_dout[WIDTH-1:0] = r_pcmsk;
        RegPcif:  io_dout[0]         = r_flag;
        default:  io_dout            = 8'h00;
      endcase
    end
  end

  assign pin_out = r_port;
  assign pin_en  = r_ddr;
  assign irq     = r_flag;

endmodule

// File: tb/tb_avr_gpio_port.sv
// Directed self-checking bench for avr_gpio_port (WIDTH=8, BASE_ADDR=6'h10).
module tb_avr_gpio_port;

  localparam logic [5:0] BASE = 6'h10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] io_addr = '0;
  logic       io_we = 1'b0;
  logic       io_re = 1'b0;
  logic [7:0] io_din = '0;
  logic [7:0] io_dout;
  logic [7:0] pin_out;
  logic [7:0] pin_en;
  logic [7:0] pin_in = '0;
  logic       irq;

  int n_tests = 0;
  int n_fail  = 0;

  avr_gpio_port #(
    .WIDTH(8),
    .BASE_ADDR(BASE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io_addr(io_addr),
    .io_we(io_we),
    .io_re(io_re),
    .io_din(io_din),
    .io_dout(io_dout),
    .pin_out(pin_out),
    .pin_en(pin_en),
    .pin_in(pin_in),
    .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic io_write(input logic [5:0] a, input logic [7:0] d);
    @(negedge clk);
    io_addr = a;
    io_din  = d;
    io_we   = 1'b1;
    @(posedge clk);
    #1;
    io_we   = 1'b0;
  endtask

  task automatic io_read(input logic [5:0] a, output logic [7:0] d);
    io_addr = a;
    io_re   = 1'b1;
    #1;
    d       = io_dout;
    io_re   = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [7:0] d;
    rst    = 1'b1;
    pin_in = 8'h3C;
    cycles(2);
    io_read(BASE, d);
    n_tests++;
    if (d !== 8'h00) begin n_fail++; $display("FAIL reset_dout_in_rst got %h exp 00", d); end
    @(negedge clk);
    rst = 1'b0;
    cycles(3);
    n_tests++;
    if (pin_en !== 8'h00 || pin_out !== 8'h00 || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs got en=%h out=%h irq=%b exp 00/00/0", pin_en, pin_out, irq);
    end
    io_read(BASE + 6'd1, d);
    n_tests++;
    if (d !== 8'h00) begin n_fail++; $display("FAIL reset_ddr got %h exp 00", d); end
    io_read(BASE + 6'd2, d);
    n_tests++;
    if (d !== 8'h00) begin n_fail++; $display("FAIL reset_port got %h exp 00", d); end
    io_read(BASE + 6'd3, d);
    n_tests++;
    if (d !== 8'h00) begin n_fail++; $display("FAIL reset_pcmsk got %h exp 00", d); end
    io_read(BASE + 6'd4, d);
    n_tests++;
    if (d !== 8'h00) begin n_fail++; $display("FAIL reset_pcif got %h exp 00", d); end
    io_read(BASE, d);
    n_tests++;
    if (d !== 8'h3C) begin n_fail++; $display("FAIL reset_pin got %h exp 3c", d); end
  endtask

  task automatic test_write;
    logic [7:0] d;
    io_write(BASE + 6'd1, 8'hF0);
    io_write(BASE + 6'd2, 8'hA5);
    n_tests++;
    if (pin_en !== 8'hF0 || pin_out !== 8'hA5) begin
      n_fail++;
      $display("FAIL write_pins got en=%h out=%h exp f0/a5", pin_en, pin_out);
    end
    io_read(BASE + 6'd1, d);
    n_tests++;
    if (d !== 8'hF0) begin n_fail++; $display("FAIL write_ddr_rb got %h exp f0", d); end
    io_read(BASE + 6'd2, d);
    n_tests++;
    if (d !== 8'hA5) begin n_fail++; $display("FAIL write_port_rb got %h exp a5", d); end
    io_write(BASE, 8'h0F);
    io_read(BASE + 6'd2, d);
    n_tests++;
    if (d !== 8'hAA || pin_out !== 8'hAA) begin
      n_fail++;
      $display("FAIL pin_toggle got rd=%h out=%h exp aa", d, pin_out);
    end
  endtask

  task automatic test_sync;
    logic [7:0] d;
    @(negedge clk);
    pin_in = 8'h00;
    cycles(4);
    @(negedge clk);
    pin_in = 8'h01;
    io_read(BASE, d);
    n_tests++;
    if (d !== 8'h00) begin n_fail++; $display("FAIL sync_before_n got %h exp 00", d); end
    @(posedge clk);
    #1;
    io_read(BASE, d);
    n_tests++;
    if (d !== 8'h00) begin n_fail++; $display("FAIL sync_after_n got %h exp 00", d); end
    @(posedge clk);
    #1;
    io_read(BASE, d);
    n_tests++;
    if (d !== 8'h01) begin n_fail++; $display("FAIL sync_after_n1 got %h exp 01", d); end
  endtask

  task automatic test_pcint;
    logic [7:0] d;
    io_write(BASE + 6'd3, 8'h01);
    n_tests++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL mask_no_event got %b exp 0", irq); end
    @(negedge clk);
    pin_in = 8'h00;
    @(posedge clk);
    #1;
    n_tests++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL pc_after_n got %b exp 0", irq); end
    @(posedge clk);
    #1;
    n_tests++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL pc_after_n1 got %b exp 0", irq); end
    @(posedge clk);
    #1;
    n_tests++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL pc_after_n2 got %b exp 1", irq); end
    io_read(BASE + 6'd4, d);
    n_tests++;
    if (d !== 8'h01) begin n_fail++; $display("FAIL pcif_read got %h exp 01", d); end
    io_write(BASE + 6'd4, 8'h00);
    n_tests++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL pcif_write0 got %b exp 1", irq); end
    io_write(BASE + 6'd4, 8'h01);
    n_tests++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL pcif_clear got %b exp 0", irq); end
    @(negedge clk);
    pin_in = 8'h02;
    cycles(5);
    n_tests++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL unmasked_pin got %b exp 0", irq); end
  endtask

  task automatic test_race;
    @(negedge clk);
    pin_in = 8'h03;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    io_addr = BASE + 6'd4;
    io_din  = 8'h01;
    io_we   = 1'b1;
    @(posedge clk);
    #1;
    io_we = 1'b0;
    n_tests++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL race_set_wins got %b exp 1", irq); end
    cycles(3);
    n_tests++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL race_hold got %b exp 1", irq); end
    io_write(BASE + 6'd4, 8'h01);
    n_tests++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL race_clear got %b exp 0", irq); end
  endtask

  task automatic test_decode;
    logic [7:0] d;
    io_write(BASE + 6'd5, 8'hFF);
    io_write(BASE - 6'd1, 8'hFF);
    io_write(6'h20, 8'h55);
    io_write(6'h00, 8'h33);
    n_tests++;
    if (pin_en !== 8'hF0 || pin_out !== 8'hAA || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL decode_noop got en=%h out=%h irq=%b exp f0/aa/0", pin_en, pin_out, irq);
    end
    io_read(BASE + 6'd3, d);
    n_tests++;
    if (d !== 8'h01) begin n_fail++; $display("FAIL decode_pcmsk got %h exp 01", d); end
    io_read(BASE + 6'd5, d);
    n_tests++;
    if (d !== 8'h00) begin n_fail++; $display("FAIL decode_ofs5_rd got %h exp 00", d); end
    io_addr = BASE + 6'd1;
    io_re   = 1'b0;
    #1;
    n_tests++;
    if (io_dout !== 8'h00) begin n_fail++; $display("FAIL decode_no_re got %h exp 00", io_dout); end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    pin_in = 8'h02;
    cycles(4);
    n_tests++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL mid_setup got %b exp 1", irq); end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_tests++;
    if (irq !== 1'b0 || pin_en !== 8'h00 || pin_out !== 8'h00) begin
      n_fail++;
      $display("FAIL mid_reset got irq=%b en=%h out=%h exp 0/00/00", irq, pin_en, pin_out);
    end
    @(negedge clk);
    rst = 1'b0;
    cycles(4);
    n_tests++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL mid_after got %b exp 0", irq); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_sync();
    test_pcint();
    test_race();
    test_decode();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
